// File: rtl/mc_control_unit.sv
// Multi-cycle RV32I control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with bus-timeout and illegal-instruction traps.
// Optional feature macro CU_MULDIV_EN: adds the MULDIV state for M-extension R-type ops (otherwise they trap as illegal).
module mc_control_unit #(
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             mem_ready,
  input  logic             branch_taken,
  input  logic             md_done,
  output logic             ir_en,
  output logic             pc_en,
  output logic             reg_we,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             alu_src_b,
  output logic             pc_sel,
  output logic [1:0]       wb_sel,
  output logic [2:0]       imm_sel,
  output logic [1:0]       alu_src_a,
  output logic [3:0]       alu_ctrl,
  output logic [2:0]       byte_sel,
  output logic             md_start,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] instret
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_MULDIV, S_TRAP} state_t;
  typedef enum logic [3:0] {C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_LUI, C_AUIPC,
                            C_JAL, C_JALR, C_MD, C_BAD} cls_t;

  state_t           r_state;
  logic [31:0]      r_ir;
  logic [7:0]       r_wait;
  logic             r_illegal;
  logic             r_bus_err;
  logic [CNT_W-1:0] r_instret;
`ifdef CU_MULDIV_EN
  logic             r_md_first;
`endif

  cls_t       w_cls;
  logic [2:0] w_funct3;
  logic       w_rd_nz;
  logic       w_legal;
  logic       w_timeout;
  logic [2:0] w_imm_sel;
  logic [1:0] w_src_a;
  logic       w_src_b;
  logic [3:0] w_alu_ctrl;
  logic       w_unused;

  assign w_funct3  = r_ir[14:12];
  assign w_rd_nz   = (r_ir[11:7] != 5'd0);
  assign w_timeout = (r_wait == WAIT_LIMIT);
  // Register-select fields belong to the datapath; XLEN only sizes the datapath.
  assign w_unused  = ^{md_done, r_ir[24:15], XLEN > 0};

  assign illegal = r_illegal;
  assign bus_err = r_bus_err;
  assign instret = r_instret;

  always_comb begin
    w_cls = C_BAD;
    case (r_ir[6:0])
      OP_R:      w_cls = (r_ir[31:25] == 7'b0000001) ? C_MD : C_R;
      OP_I:      w_cls = C_I;
      OP_LOAD:   w_cls = C_LOAD;
      OP_STORE:  w_cls = C_STORE;
      OP_BRANCH: w_cls = C_BRANCH;
      OP_LUI:    w_cls = C_LUI;
      OP_AUIPC:  w_cls = C_AUIPC;
      OP_JAL:    w_cls = C_JAL;
      OP_JALR:   w_cls = C_JALR;
      default:   w_cls = C_BAD;
    endcase
  end

`ifdef CU_MULDIV_EN
  assign w_legal = (w_cls != C_BAD);
`else
  assign w_legal = (w_cls != C_BAD) && (w_cls != C_MD);
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_imm_sel  = 3'd0;
    w_src_a    = 2'd0;
    w_src_b    = 1'b1;
    w_alu_ctrl = 4'b0000;
    case (w_cls)
      C_R, C_MD: begin
        w_src_b    = 1'b0;
        w_alu_ctrl = {r_ir[30], w_funct3};
      end
      C_I:      w_alu_ctrl = {(w_funct3 == 3'b101) & r_ir[30], w_funct3};
      C_STORE:  w_imm_sel = 3'd1;
      C_BRANCH: begin
        w_imm_sel  = 3'd2;
        w_src_a    = 2'd1;
        w_alu_ctrl = {1'b0, w_funct3};
      end
      C_LUI:    begin w_imm_sel = 3'd3; w_src_a = 2'd2; end
      C_AUIPC:  begin w_imm_sel = 3'd3; w_src_a = 2'd1; end
      C_JAL:    begin w_imm_sel = 3'd4; w_src_a = 2'd1; end
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_FETCH;
      r_ir       <= '0;
      r_wait     <= '0;
      r_illegal  <= 1'b0;
      r_bus_err  <= 1'b0;
      r_instret  <= '0;
`ifdef CU_MULDIV_EN
      r_md_first <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments; the last one in the block wins, so the wait-counter
      // clear below is overridden only when the state is held waiting on memory.
      r_wait <= '0;
      if (pc_en) r_instret <= r_instret + CNT_W'(1);
      case (r_state)
        S_FETCH: begin
          if (mem_ready) begin
            r_ir    <= instr;
            r_state <= S_DECODE;
          end else if (w_timeout) begin
            r_state   <= S_TRAP;
            r_bus_err <= 1'b1;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        S_DECODE: begin
          if (w_legal) begin
            r_state <= S_EXEC;
          end else begin
            r_state   <= S_TRAP;
            r_illegal <= 1'b1;
          end
        end
        S_EXEC: begin
          case (w_cls)
            C_BRANCH:        r_state <= S_FETCH;
            C_LOAD, C_STORE: r_state <= S_MEM;
`ifdef CU_MULDIV_EN
            C_MD: begin
              r_state    <= S_MULDIV;
              r_md_first <= 1'b1;
            end
`endif
            default:         r_state <= S_WB;
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            r_state <= (w_cls == C_LOAD) ? S_WB : S_FETCH;
          end else if (w_timeout) begin
            r_state   <= S_TRAP;
            r_bus_err <= 1'b1;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        S_WB:     r_state <= S_FETCH;
        S_MULDIV: begin
`ifdef CU_MULDIV_EN
          r_md_first <= 1'b0;
          if (md_done) r_state <= S_WB;
`else
          r_state <= S_TRAP;
`endif
        end
        default:  r_state <= S_TRAP;
      endcase
    end
  end

  // Strobes are gated by rst so an asserted reset silences them in the same cycle.
  always_comb begin
    ir_en        = 1'b0;
    pc_en        = 1'b0;
    reg_we       = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    alu_src_b    = 1'b0;
    pc_sel       = 1'b0;
    wb_sel       = 2'd0;
    imm_sel      = 3'd0;
    alu_src_a    = 2'd0;
    alu_ctrl     = 4'd0;
    byte_sel     = 3'd0;
    md_start     = 1'b0;
    if (rst) begin
      if (r_state inside {S_EXEC, S_MEM, S_WB}) begin
        alu_src_a = w_src_a;
        alu_src_b = w_src_b;
        alu_ctrl  = w_alu_ctrl;
      end
      if (r_state inside {S_DECODE, S_EXEC, S_MEM, S_WB}) imm_sel = w_imm_sel;
      case (r_state)
        S_FETCH: begin
          mem_req = 1'b1;
          ir_en   = mem_ready;
        end
        S_EXEC: begin
          if (w_cls == C_BRANCH) begin
            pc_en  = 1'b1;
            pc_sel = branch_taken;
          end
        end
        S_MEM: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = (w_cls == C_STORE);
          byte_sel     = w_funct3;
          pc_en        = mem_ready && (w_cls == C_STORE);
        end
        S_WB: begin
          pc_en  = 1'b1;
          reg_we = w_rd_nz;
          case (w_cls)
            C_JAL, C_JALR: begin wb_sel = 2'd2; pc_sel = 1'b1; end
            C_LOAD:        wb_sel = 2'd1;
            C_MD:          wb_sel = 2'd3;
            default:       wb_sel = 2'd0;
          endcase
        end
        S_MULDIV: begin
`ifdef CU_MULDIV_EN
          md_start = r_md_first;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// Randomized self-checking bench for mc_control_unit: a per-instruction cycle schedule model
// derived from the instruction class, wait counts and branch outcome.
module tb_mc_control_unit;

  localparam int MAX_WAIT = 15;
  localparam int CNT_W    = 4;
`ifdef CU_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      instr;
  logic             mem_ready, branch_taken, md_done;
  logic             ir_en, pc_en, reg_we, mem_req, mem_we, mem_addr_sel, alu_src_b, pc_sel;
  logic [1:0]       wb_sel, alu_src_a;
  logic [2:0]       imm_sel, byte_sel;
  logic [3:0]       alu_ctrl;
  logic             md_start, illegal, bus_err;
  logic [CNT_W-1:0] instret;

  always #5 clk = ~clk;

  mc_control_unit #(.XLEN(32), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .md_done(md_done),
    .ir_en(ir_en), .pc_en(pc_en), .reg_we(reg_we), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .alu_src_b(alu_src_b), .pc_sel(pc_sel), .wb_sel(wb_sel),
    .imm_sel(imm_sel), .alu_src_a(alu_src_a), .alu_ctrl(alu_ctrl), .byte_sel(byte_sel),
    .md_start(md_start), .illegal(illegal), .bus_err(bus_err), .instret(instret)
  );

  typedef struct packed {
    logic       ir_en, pc_en, reg_we, mem_req, mem_we, mem_addr_sel, alu_src_b, pc_sel;
    logic [1:0] wb_sel;
    logic [2:0] imm_sel;
    logic [1:0] alu_src_a;
    logic [3:0] alu_ctrl;
    logic [2:0] byte_sel;
    logic       md_start, illegal, bus_err;
  } outs_t;

  typedef enum int {K_R, K_I, K_LD, K_ST, K_BR, K_LUI, K_AUI, K_JAL, K_JALR, K_MD, K_BAD} kind_t;

  outs_t            obs;
  int               n_vec = 0;
  int               n_bad = 0;
  logic [CNT_W-1:0] exp_instret;
  logic             exp_ill, exp_berr;

  assign obs = {ir_en, pc_en, reg_we, mem_req, mem_we, mem_addr_sel, alu_src_b, pc_sel,
                wb_sel, imm_sel, alu_src_a, alu_ctrl, byte_sel, md_start, illegal, bus_err};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s @%0t: observed=%h expected=%h", tag, $time, got, want);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic kind_t kind_of(input logic [31:0] ins);
    case (ins[6:0])
      7'h33:   return (ins[31:25] == 7'h01) ? K_MD : K_R;
      7'h13:   return K_I;
      7'h03:   return K_LD;
      7'h23:   return K_ST;
      7'h63:   return K_BR;
      7'h37:   return K_LUI;
      7'h17:   return K_AUI;
      7'h6F:   return K_JAL;
      7'h67:   return K_JALR;
      default: return K_BAD;
    endcase
  endfunction

  // Immediate format and ALU operand/operation for each instruction class.
  function automatic outs_t view(input logic [31:0] ins);
    outs_t      v  = '0;
    logic [2:0] f3 = ins[14:12];
    case (kind_of(ins))
      K_R, K_MD: v.alu_ctrl = {ins[30], f3};
      K_I:       begin v.alu_src_b = 1; v.alu_ctrl = {f3 == 3'd5 && ins[30], f3}; end
      K_LD:      v.alu_src_b = 1;
      K_JALR:    v.alu_src_b = 1;
      K_ST:      begin v.alu_src_b = 1; v.imm_sel = 3'd1; end
      K_BR:      begin v.alu_src_b = 1; v.imm_sel = 3'd2; v.alu_src_a = 2'd1; v.alu_ctrl = {1'b0, f3}; end
      K_LUI:     begin v.alu_src_b = 1; v.imm_sel = 3'd3; v.alu_src_a = 2'd2; end
      K_AUI:     begin v.alu_src_b = 1; v.imm_sel = 3'd3; v.alu_src_a = 2'd1; end
      K_JAL:     begin v.alu_src_b = 1; v.imm_sel = 3'd4; v.alu_src_a = 2'd1; end
      default:   ;
    endcase
    return v;
  endfunction

  // One clock cycle: entered and left at a falling edge; outputs sampled 1 ns after driving.
  task automatic cyc(input string tag, input logic rdy, input logic bt, input logic mdd,
                     input outs_t e, input logic retire);
    mem_ready = rdy; branch_taken = bt; md_done = mdd;
    #1;
    check({tag, "/outs"}, 64'(obs), 64'(e));
    check({tag, "/instret"}, 64'(instret), 64'(exp_instret));
    @(posedge clk);
    if (retire) exp_instret = exp_instret + 1'b1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    mem_ready = 1'b1; branch_taken = 1'b1; md_done = 1'b1;
    #2 rst = 1'b0;
    exp_instret = '0; exp_ill = 1'b0; exp_berr = 1'b0;
    #1;
    check("reset_outs", 64'(obs), 64'(0));
    check("reset_instret", 64'(instret), 64'(exp_instret));
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic trap_hold();
    outs_t e = '0;
    e.illegal = exp_ill;
    e.bus_err = exp_berr;
    for (int i = 0; i < 3; i++) cyc("trap", rb(), rb(), rb(), e, 1'b0);
    do_reset();
  endtask

  task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                           input logic bt, input int mdl);
    kind_t k;
    outs_t v, e;
    k = kind_of(ins);
    v = view(ins);
    instr = ins;
    for (int i = 0; i < fw && i <= MAX_WAIT; i++) begin
      e = '0; e.mem_req = 1'b1;
      cyc("fetch_wait", 1'b0, rb(), rb(), e, 1'b0);
    end
    if (fw > MAX_WAIT) begin
      exp_berr = 1'b1;
      trap_hold();
      return;
    end
    e = '0; e.mem_req = 1'b1; e.ir_en = 1'b1;
    cyc("fetch", 1'b1, rb(), rb(), e, 1'b0);
    instr = $urandom;
    e = '0; e.imm_sel = v.imm_sel;
    cyc("decode", rb(), rb(), rb(), e, 1'b0);
    if (k == K_BAD || (k == K_MD && !MD_EN)) begin
      exp_ill = 1'b1;
      trap_hold();
      return;
    end
    e = v;
    if (k == K_BR) begin
      e.pc_en = 1'b1; e.pc_sel = bt;
      cyc("exec_branch", rb(), bt, rb(), e, 1'b1);
      return;
    end
    cyc("exec", rb(), rb(), rb(), e, 1'b0);
    if (k == K_LD || k == K_ST) begin
      e = v; e.mem_req = 1'b1; e.mem_addr_sel = 1'b1;
      e.mem_we = (k == K_ST); e.byte_sel = ins[14:12];
      for (int i = 0; i < mw && i <= MAX_WAIT; i++) cyc("mem_wait", 1'b0, rb(), rb(), e, 1'b0);
      if (mw > MAX_WAIT) begin
        exp_berr = 1'b1;
        trap_hold();
        return;
      end
      if (k == K_ST) begin
        e.pc_en = 1'b1;
        cyc("mem_store", 1'b1, rb(), rb(), e, 1'b1);
        return;
      end
      cyc("mem_load", 1'b1, rb(), rb(), e, 1'b0);
    end
    if (k == K_MD) begin
      for (int i = 0; i <= mdl; i++) begin
        e = '0; e.md_start = (i == 0);
        cyc("muldiv", rb(), rb(), i == mdl, e, 1'b0);
      end
    end
    e = v; e.pc_en = 1'b1; e.reg_we = (ins[11:7] != 5'd0);
    case (k)
      K_JAL, K_JALR: begin e.wb_sel = 2'd2; e.pc_sel = 1'b1; end
      K_LD:          e.wb_sel = 2'd1;
      K_MD:          e.wb_sel = 2'd3;
      default:       ;
    endcase
    cyc("wb", rb(), rb(), rb(), e, 1'b1);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r = $urandom;
    logic [6:0]  ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h33};
    logic [6:0]  bad [4]  = '{7'h7F, 7'h00, 7'h0F, 7'h73};
    int          pick = $urandom_range(0, 10);
    if (pick == 10) begin
      r[6:0] = bad[$urandom_range(0, 3)];
    end else begin
      r[6:0] = ops[pick];
      if (pick == 0) r[31:25] = rb() ? 7'h20 : 7'h00;
      if (pick == 9) r[31:25] = 7'h01;
    end
    return r;
  endfunction

  function automatic int rand_wait();
    int p = $urandom_range(0, 24);
    if (p == 0) return MAX_WAIT + 1;
    if (p == 1) return MAX_WAIT;
    return $urandom_range(0, 2);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    outs_t e;
    rst = 1'b0; instr = '0; mem_ready = 1'b1; branch_taken = 1'b1; md_done = 1'b1;
    exp_instret = '0; exp_ill = 1'b0; exp_berr = 1'b0;
    #1;
    check("reset_outs", 64'(obs), 64'(0));
    check("reset_instret", 64'(instret), 64'(exp_instret));
    @(negedge clk);
    rst = 1'b1;

    run_instr(32'h002081B3, 0, 0, 1'b0, 0);          // ADD x3,x1,x2
    run_instr(32'h0080A283, 0, 3, 1'b0, 0);          // LW x5,8(x1), memory slow 3 cycles
    run_instr(32'h00208463, 0, 0, 1'b1, 0);          // BEQ taken
    run_instr(32'h00208463, 0, 0, 1'b0, 0);          // BEQ not taken
    run_instr(32'h0020A623, 0, 0, 1'b0, 0);          // SW x2,12(x1)
    run_instr(32'h010000EF, 0, 0, 1'b0, 0);          // JAL x1,+16
    run_instr(32'h4020D013, 0, 0, 1'b0, 0);          // SRAI x0 (rd=0 so no write)
    run_instr(32'h002081B3, MAX_WAIT, 0, 1'b0, 0);   // ready on the limit cycle completes
    run_instr(32'h0080A283, 0, MAX_WAIT, 1'b0, 0);
    run_instr(32'h002081B3, MAX_WAIT + 1, 0, 1'b0, 0); // fetch bus timeout
    run_instr(32'h0080A283, 0, MAX_WAIT + 1, 1'b0, 0); // memory-phase bus timeout
    run_instr(32'h0000007F, 0, 0, 1'b0, 0);          // unknown opcode
    run_instr(32'h022081B3, 0, 0, 1'b0, 2);          // MUL x3,x1,x2

    // Reset asserted in the middle of a load's memory phase.
    instr = 32'h0080A283;
    e = '0; e.mem_req = 1'b1; e.ir_en = 1'b1;
    cyc("abort_fetch", 1'b1, 1'b0, 1'b0, e, 1'b0);
    instr = $urandom;
    e = '0;
    cyc("abort_decode", 1'b0, 1'b0, 1'b0, e, 1'b0);
    e = view(32'h0080A283);
    cyc("abort_exec", 1'b0, 1'b0, 1'b0, e, 1'b0);
    e.mem_req = 1'b1; e.mem_addr_sel = 1'b1; e.byte_sel = 3'b010;
    cyc("abort_mem", 1'b0, 1'b0, 1'b0, e, 1'b0);
    do_reset();

    for (int n = 0; n < 300; n++)
      run_instr(rand_instr(), rand_wait(), rand_wait(), rb(), $urandom_range(0, 3));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
